// File: rtl/aes_pkg.sv
// Shared definitions for the AES round datapath: byte/column types and the
// ShiftRows row-offset tables for Nb = 4, 6 and 8.
package aes_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] col_t;

    // Entry [r] is the left-rotation offset of state row r.
    localparam logic [3:0][3:0] SHIFT_NB4 = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [3:0][3:0] SHIFT_NB6 = {4'd3, 4'd2, 4'd1, 4'd0};
    localparam logic [3:0][3:0] SHIFT_NB8 = {4'd4, 4'd3, 4'd1, 4'd0};

    function automatic int shift_off(input int nb, input int row);
        logic [1:0] r;
        logic [3:0] off;
        r = row[1:0];
        case (nb)
            8:       off = SHIFT_NB8[r];
            6:       off = SHIFT_NB6[r];
            default: off = SHIFT_NB4[r];
        endcase
        return int'(off);
    endfunction

endpackage

// File: rtl/aes_shiftrows_perm.sv
// Combinational ShiftRows / InvShiftRows byte routing for an Nb-column state.
// Byte s[r][c] lives at bits W-1-8*(4c+r) -: 8.
module aes_shiftrows_perm
    import aes_pkg::*;
#(
    parameter int NB = 4
) (
    input  logic              inv,
    input  logic [32*NB-1:0]  state_in,
    output logic [32*NB-1:0]  state_out
);

    localparam int W = 32 * NB;

    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            localparam int OFF     = shift_off(NB, r);
            localparam int SRC_FWD = (c + OFF) % NB;
            localparam int SRC_INV = (c - OFF + NB) % NB;

            byte_t fwd_b;
            byte_t inv_b;

            assign fwd_b = state_in[W-1-8*(4*SRC_FWD+r) -: 8];
            assign inv_b = state_in[W-1-8*(4*SRC_INV+r) -: 8];
            assign state_out[W-1-8*(4*c+r) -: 8] = inv ? inv_b : fwd_b;
        end
    end

endmodule

// File: rtl/aes_shiftrows_pipe.sv
// Pipelined, valid/ready ShiftRows/InvShiftRows unit with a sideband tag.
// Optional per-byte odd-parity carry and checking under AES_SR_PARITY_EN.
module aes_shiftrows_pipe
    import aes_pkg::*;
#(
    parameter int NB     = 4,
    parameter int STAGES = 2,
    parameter int TAG_W  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_inv,
    input  logic [TAG_W-1:0]   in_tag,
    input  logic [32*NB-1:0]   in_state,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [TAG_W-1:0]   out_tag,
    output logic [32*NB-1:0]   out_state
`ifdef AES_SR_PARITY_EN
    ,
    input  logic [NB*4-1:0]    in_par,
    output logic [NB*4-1:0]    out_par,
    output logic               par_err
`endif
);

    localparam int W = 32 * NB;
`ifdef AES_SR_PARITY_EN
    localparam int SW = TAG_W + NB * 4;
`else
    localparam int SW = TAG_W;
`endif

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("aes_shiftrows_pipe: STAGES must be 1..4");
    end

    logic [STAGES-1:0] valid_q, valid_d;
    logic [W-1:0]      state_q [STAGES];
    logic [W-1:0]      state_d [STAGES];
    logic [SW-1:0]     side_q  [STAGES];
    logic [SW-1:0]     side_d  [STAGES];

    logic [STAGES-1:0] src_valid;
    logic [W-1:0]      src_state [STAGES];
    logic [SW-1:0]     src_side  [STAGES];

    logic [STAGES-1:0] load;
    logic              full_tail;
    logic [W-1:0]      perm_state;
    logic [SW-1:0]     in_side;

    aes_shiftrows_perm #(.NB(NB)) u_perm (
        .inv       (in_inv),
        .state_in  (in_state),
        .state_out (perm_state)
    );

`ifdef AES_SR_PARITY_EN
    // Parity bits ride in the low bit of a byte lane so the same router permutes them.
    logic [W-1:0]    par_wide, par_wide_perm;
    logic [NB*4-1:0] par_perm;
    logic            par_bad;
    logic            par_err_q, par_err_d;

    for (genvar i = 0; i < NB * 4; i++) begin : g_par
        assign par_wide[W-1-8*i -: 8] = {7'd0, in_par[NB*4-1-i]};
        assign par_perm[NB*4-1-i]     = par_wide_perm[W-8-8*i];
    end

    aes_shiftrows_perm #(.NB(NB)) u_par_perm (
        .inv       (in_inv),
        .state_in  (par_wide),
        .state_out (par_wide_perm)
    );

    always_comb begin
        par_bad = 1'b0;
        for (int i = 0; i < NB * 4; i++) begin
            par_bad = par_bad | ~(^{in_state[W-1-8*i -: 8], in_par[NB*4-1-i]});
        end
    end

    assign in_side   = {par_perm, in_tag};
    assign par_err_d = flush ? 1'b0 : (par_err_q | (in_valid & in_ready & par_bad));

    always_ff @(posedge clk) begin
        if (!rst_n) par_err_q <= 1'b0;
        else        par_err_q <= par_err_d;
    end

    assign par_err = par_err_q;
    assign out_par = side_q[STAGES-1][SW-1:TAG_W];
`else
    assign in_side = in_tag;
`endif

    // A stage can load if it or any stage behind it toward the output is empty.
    always_comb begin
        full_tail = 1'b1;
        load      = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail & valid_q[k];
            load[k]   = out_ready | ~full_tail;
        end
    end

    assign in_ready = load[0] & ~flush;

    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_head
            assign src_valid[k] = in_valid & ~flush;
            assign src_state[k] = perm_state;
            assign src_side[k]  = in_side;
        end else begin : g_body
            assign src_valid[k] = valid_q[k-1];
            assign src_state[k] = state_q[k-1];
            assign src_side[k]  = side_q[k-1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        state_d = state_q;
        side_d  = side_q;
        for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
                valid_d[k] = src_valid[k];
                if (src_valid[k]) begin
                    state_d[k] = src_state[k];
                    side_d[k]  = src_side[k];
                end
            end
        end
        if (flush) valid_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                state_q[k] <= '0;
                side_q[k]  <= '0;
            end
        end else begin
            valid_q <= valid_d;
            state_q <= state_d;
            side_q  <= side_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_state = state_q[STAGES-1];
    assign out_tag   = side_q[STAGES-1][TAG_W-1:0];

endmodule
